// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: shift-and-add multiply sequencer that borrows the shared ALU.
// It produces the low DATA_WIDTH bits of op_a * op_b in a fixed DATA_WIDTH+1
// cycle start-to-done latency. While alu_req is high, an external ownership mux
// routes alu_srca/alu_srcb/alu_operation to the ALU. alu_result is consumed
// combinationally. The operands driven to the ALU come straight from registers,
// so no combinational loop passes through the ALU.
module mul_seq_ctrl #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    op_a,
    input  logic [DATA_WIDTH-1:0]    op_b,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    product,
    output logic                     alu_req,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_operation,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);
    localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] ALU_NOP = OPCODE_LENGTH'(4'b0000);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    acc_q, acc_d;
    logic [DATA_WIDTH-1:0]    mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]    mplier_q, mplier_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0]    product_q, product_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     alu_req_q, alu_req_d;
    logic [OPCODE_LENGTH-1:0] alu_op_q, alu_op_d;

    // State, datapath and output registers; synchronous reset wins over start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            alu_req_q <= 1'b0;
            alu_op_q  <= ALU_NOP;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            alu_req_q <= alu_req_d;
            alu_op_q  <= alu_op_d;
        end
    end

    // Next-state, datapath step and registered-output decode of the next state.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // ALU computes acc + mcand from the registered operands.
                if (mplier_q[0]) begin
                    acc_d = alu_result;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                if (count_q == LAST_STEP) begin
                    state_d   = DONE;
                    product_d = acc_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        alu_req_d = (state_d == RUN);
        alu_op_d  = (state_d == RUN) ? ALU_ADD : ALU_NOP;
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign product       = product_q;
    assign alu_req       = alu_req_q;
    assign alu_srca      = acc_q;
    assign alu_srcb      = mcand_q;
    assign alu_operation = alu_op_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: arithmetic reference model plus directed multiplies.
module tb_mul_seq_ctrl;

    localparam int DW = 32;
    localparam int OL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          busy;
    logic          done;
    logic [DW-1:0] product;
    logic          alu_req;
    logic [DW-1:0] alu_srca;
    logic [DW-1:0] alu_srcb;
    logic [OL-1:0] alu_operation;
    logic [DW-1:0] alu_result;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    mul_seq_ctrl #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .op_a          (op_a),
        .op_b          (op_b),
        .busy          (busy),
        .done          (done),
        .product       (product),
        .alu_req       (alu_req),
        .alu_srca      (alu_srca),
        .alu_srcb      (alu_srcb),
        .alu_operation (alu_operation),
        .alu_result    (alu_result)
    );

    always #5 clk = ~clk;

    // Shared ALU behind the ownership mux: other traffic shows up when not owned.
    assign alu_result = !alu_req ? 32'hDEADBEEF :
                        (alu_operation == 4'b0010) ? (alu_srca + alu_srcb) : 32'hBAD0BAD0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1..DW running, DW+1 done; k = steps taken.
    int               m_ph = 0;
    int               m_k  = 0;
    longint unsigned  m_a  = 0;
    longint unsigned  m_b  = 0;
    logic [DW-1:0]    m_prod = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_ph <= 0; m_k <= 0; m_a <= 0; m_b <= 0; m_prod <= '0;
        end else if (m_ph == 0) begin
            if (start) begin
                m_ph <= 1; m_k <= 0;
                m_a <= 64'(op_a); m_b <= 64'(op_b);
            end
        end else if (m_ph == DW + 1) begin
            m_ph <= 0;
        end else begin
            m_ph <= m_ph + 1;
            m_k  <= m_k + 1;
            if (m_ph == DW) m_prod <= 32'(m_a * m_b);
        end
    end

    // Every-cycle comparison: accumulator is the partial product of the low k multiplier bits.
    logic [DW-1:0] e_acc;
    logic [DW-1:0] e_mc;
    logic          e_run;
    always @(negedge clk) begin
        if (chk_en) begin
            e_acc = 32'(m_a * (m_b & ((64'd1 << m_k) - 64'd1)));
            e_mc  = 32'(m_a << m_k);
            e_run = (m_ph >= 1) && (m_ph <= DW);
            chk("busy",     64'(busy),     64'(m_ph != 0));
            chk("done",     64'(done),     64'(m_ph == DW + 1));
            chk("alu_req",  64'(alu_req),  64'(e_run));
            chk("alu_op",   64'(alu_operation), e_run ? 64'd2 : 64'd0);
            chk("product",  64'(product),  64'(m_prod));
            chk("alu_srca", 64'(alu_srca), 64'(e_acc));
            chk("alu_srcb", 64'(alu_srcb), 64'(e_mc));
        end
    end

    // Called just after a negedge in IDLE; optional extra start pulse at pulse_cyc.
    task automatic do_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] exp, input int pulse_cyc);
        int cyc;
        int reqs;
        bit seen;
        start = 1'b1; op_a = a; op_b = b;
        cyc = 0; reqs = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0; op_a = $urandom; op_b = $urandom;
            end
            if (cyc == pulse_cyc) begin
                start = 1'b1; op_a = 32'd100; op_b = 32'd100;
            end
            if (cyc == pulse_cyc + 1) start = 1'b0;
            if (alu_req) reqs++;
            if (done) seen = 1'b1;
        end
        chk("done_cycle", 64'(cyc), 64'd33);
        chk("product_lit", 64'(product), 64'(exp));
        chk("model_prod_lit", 64'(m_prod), 64'(exp));
        chk("alu_req_cycles", 64'(reqs), 64'd32);
        @(negedge clk);
        chk("busy_low_c34", 64'(busy), 64'd0);
    endtask

    int ndone;
    int cyc;

    initial begin
        reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_alu_req", 64'(alu_req), 64'd0);
        chk("rst_srca", 64'(alu_srca), 64'd0);
        chk("rst_srcb", 64'(alu_srcb), 64'd0);
        chk("rst_op", 64'(alu_operation), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_mul(32'd3, 32'd5, 32'd15, -5);
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, -5);
        do_mul(32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, -5);
        do_mul(32'h00010000, 32'h00010000, 32'h0, -5);
        do_mul(32'h01234567, 32'h0, 32'h0, -5);

        // start pulsed while busy is dropped, not queued
        do_mul(32'd2, 32'd9, 32'd18, 10);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("no_second_done", 64'(ndone), 64'd0);

        // reset in the middle of a 7x7
        start = 1'b1; op_a = 32'd7; op_b = 32'd7;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_product", 64'(product), 64'd0);
        chk("mid_rst_alu_req", 64'(alu_req), 64'd0);
        chk("mid_rst_srca", 64'(alu_srca), 64'd0);
        chk("mid_rst_srcb", 64'(alu_srcb), 64'd0);
        chk("mid_rst_op", 64'(alu_operation), 64'd0);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("aborted_no_done", 64'(ndone), 64'd0);
        do_mul(32'd4, 32'd4, 32'd16, -5);

        // start held high: back-to-back multiplies
        start = 1'b1; op_a = 32'd10; op_b = 32'd20;
        ndone = 0; cyc = 0;
        while (cyc < 72) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin op_a = 32'd11; op_b = 32'd3; end
            if (cyc == 35) start = 1'b0;
            if (done) begin
                if (ndone == 0) begin
                    chk("b2b_cycle0", 64'(cyc), 64'd33);
                    chk("b2b_prod0", 64'(product), 64'd200);
                end else begin
                    chk("b2b_cycle1", 64'(cyc), 64'd67);
                    chk("b2b_prod1", 64'(product), 64'd33);
                end
                ndone++;
            end
        end
        chk("b2b_done_count", 64'(ndone), 64'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Iterative shift-and-add multiply sequencer that borrows the core's shared ALU to produce the low `DATA_WIDTH` bits of `op_a * op_b`. It drives the ALU's `SrcA`, `SrcB` and `Operation` inputs through an external ownership mux while `alu_req` is high, and consumes `ALUResult`. It sits beside the execute stage as the M-extension `MUL` engine. Its latency is fixed and data-independent.

## Interface
- `DATA_WIDTH`, default 32: operand, product and ALU width.
- `OPCODE_LENGTH`, default 4: ALU operation code width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high. All registers go to their reset values on the next rising edge.
- `start`  in  1: request a multiply. Sampled only in `IDLE`.
- `op_a`  in  `DATA_WIDTH`: multiplicand. Captured when `start` is accepted.
- `op_b`  in  `DATA_WIDTH`: multiplier. Captured when `start` is accepted.
- `busy`  out  1: high in `RUN` and `DONE`.
- `done`  out  1: one-cycle pulse; `product` is valid in this cycle.
- `product`  out  `DATA_WIDTH`: low word of the result. Held until the next accepted `start`.
- `alu_req`  out  1: high only in `RUN`. While high, the external mux must route this block's ALU signals to the ALU.
- `alu_srca`  out  `DATA_WIDTH`: accumulator register.
- `alu_srcb`  out  `DATA_WIDTH`: shifted multiplicand register.
- `alu_operation`  out  `OPCODE_LENGTH`: `4'b0010` (ADD) in `RUN`, otherwise `4'b0000`.
- `alu_result`  in  `DATA_WIDTH`: combinational ALU output.

## Operation
- States: `IDLE`, `RUN`, `DONE`. Reset state is `IDLE`.
- Internal registers:
  - `acc`, `mcand`, `mplier`, each `DATA_WIDTH` bits.
  - `count`, `$clog2(DATA_WIDTH)+1` bits.
- **`IDLE`:**
  - With `start=1`: load `acc<=0`, `mcand<=op_a`, `mplier<=op_b`, `count<=0`, then go to `RUN`.
  - With `start=0`: hold.
- **`RUN`, each cycle:**
  - If `mplier[0]`: `acc<=alu_result`, which the ALU computes as `acc+mcand`. Otherwise `acc` holds.
  - `mcand<=mcand<<1`, zero fill, bits shifted out are discarded.
  - `mplier<=mplier>>1`, logical shift.
  - `count<=count+1`.
  - When `count==DATA_WIDTH-1`, go to `DONE`.
- **`DONE`:** `product` shows the final `acc`, `done=1`. Next state is `IDLE` unconditionally.
- **Arithmetic:**
  - All adds are modulo 2^`DATA_WIDTH`.
  - The result equals `(op_a*op_b) mod 2^DATA_WIDTH`, which is identical for signed and unsigned interpretation.
  - No overflow flag.
  - There is no early termination: exactly `DATA_WIDTH` `RUN` cycles, even when `op_b` is 0.
- **Output drive:**
  - `alu_srca=acc` and `alu_srcb=mcand` always; both are registered, so there is no combinational loop through the ALU.
  - The mux ignores these values when `alu_req=0`.
- **Boundary conditions:**
  - `start` in `RUN` or `DONE` is ignored and not queued. A `start` held high is accepted in the first `IDLE` cycle after `DONE`.
  - `op_a`/`op_b` changes after acceptance have no effect.
  - `reset` in any state, including mid-`RUN`: the next state is `IDLE`. All outputs return to reset values and no `done` pulse is issued for the aborted operation.
  - `reset` takes priority over `start` in the same cycle.

## Timing
- **Reset values:**
  - `busy=0`, `done=0`, `product=0`, `alu_req=0`.
  - `alu_srca=0`, `alu_srcb=0`, `alu_operation=4'b0000`.
- **Cycle numbering:** let cycle 0 be the `IDLE` edge at which `start=1` is sampled.
  - Cycles 1..`DATA_WIDTH` are `RUN`, with `alu_req=1` and `busy=1`.
  - Cycle `DATA_WIDTH+1` is `DONE`, with `done=1` and `product` valid.
  - Cycle `DATA_WIDTH+2` is `IDLE`; a new `start` can be sampled here.
- **Latency and throughput:** start-to-done latency is `DATA_WIDTH+1` cycles (33 at default). Maximum throughput is one multiply per `DATA_WIDTH+2` cycles.
- `product` only changes in the cycle entering `DONE`, or on `reset`.
- `busy` rises in cycle 1 and falls in cycle `DATA_WIDTH+2`.

## Test plan
- **Basic multiply:** reset, then `start` with `op_a=3`, `op_b=5` → `done` pulses exactly at cycle 33 with `product=15`. `alu_req` is high for exactly 32 cycles. `busy` is low at cycle 34.
- **Signed and all-ones:**
  - `op_a=32'hFFFFFFFF`, `op_b=32'hFFFFFFFF` → `product=32'h00000001`.
  - `op_a=32'hFFFFFFF9` (−7), `op_b=6` → `product=32'hFFFFFFD6` (−42).
- **Wrap and zero:**
  - `op_a=32'h00010000`, `op_b=32'h00010000` → `product=0`.
  - `op_b=0` → `product=0`, still delivered at cycle 33.
- **Start while busy:** `start` with `op_a=2`, `op_b=9`, then pulse `start` with `op_a=100`, `op_b=100` at cycle 10 → `product=18` at cycle 33. No second `done` pulse follows.
- **Reset mid-operation:** `reset` asserted at cycle 15 of a 7×7 operation → from cycle 16 all outputs are at reset values and no `done` pulse occurs. A following 4×4 multiply returns 16 with full 33-cycle latency.
- **Back-to-back:** `start` held high continuously with `op_a=10`, `op_b=20`, then `op_a=11`, `op_b=3` → `done` pulses at cycles 33 and 67 with `product` values 200 and 33.
